comp_cic_interp: RTL

COMP_CIC_INTERP -- requirements
Module: comp_cic_interp

---
 rtl/comp_cic_interp_pkg.sv | 36 +++
 rtl/comp_cic_interp_rom.sv | 36 +++
 rtl/comp_cic_interp.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/comp_cic_interp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comp_cic_interp_pkg : shared widths, tap counts, FSM states, prototype h  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package comp_cic_interp_pkg;

    localparam int Win          = 16;
    localparam int Wcoef        = 18;
    localparam int Wacc         = 38;
    localparam int NTAP0        = 9;
    localparam int NTAP1        = 8;
    localparam int c_PIPE_DEPTH = 2;
    localparam int c_TRUNC      = 17;
    localparam int c_ROM_AW     = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAC0   = 3'd1,
        S_FLUSH0 = 3'd2,
        S_MAC1   = 3'd3,
        S_FLUSH1 = 3'd4
    } state_t;

    // Symmetric 17-tap compensator prototype, S[18,17]; unused addresses are zero.
    localparam logic [Wcoef-1:0] c_COEF_DEFAULT [2**c_ROM_AW] = '{
        18'h3FE64, 18'h3FCCC, 18'h004BA, 18'h00B58, 18'h3F542, 18'h3E106,
        18'h015E0, 18'h08CA0, 18'h0EA60, 18'h08CA0, 18'h015E0, 18'h3E106,
        18'h3F542, 18'h00B58, 18'h004BA, 18'h3FCCC, 18'h3FE64,
        18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000,
        18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 18'h00000,
        18'h00000, 18'h00000, 18'h00000
    };

endpackage
`default_nettype wire

// File: rtl/comp_cic_interp_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comp_cic_interp_rom : coefficient ROM, registered read (1-cycle latency)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module comp_cic_interp_rom
    import comp_cic_interp_pkg::*;
#(
    parameter int W     = 18,
    parameter int DEPTH = 17,
    parameter logic [W-1:0] COEF [2**c_ROM_AW] = '{default: '0}
) (
    input  logic                clk,
    input  logic [c_ROM_AW-1:0] i_addr,
    output logic [W-1:0]        o_data
);

    logic [W-1:0] r_data_q;
    logic [W-1:0] w_data_d;

    // Addresses past the prototype length read as zero whatever the table holds.
    always_comb begin
        w_data_d = '0;
        if (int'(i_addr) < DEPTH) begin
            w_data_d = COEF[i_addr];
        end
    end

    always_ff @(posedge clk) begin
        r_data_q <= w_data_d;
    end

    assign o_data = r_data_q;

endmodule
`default_nettype wire

// File: rtl/comp_cic_interp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comp_cic_interp : x2 polyphase CIC-compensation interpolator, serial MAC  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module comp_cic_interp #(
    parameter int    Win       = comp_cic_interp_pkg::Win,
    parameter int    Wcoef     = comp_cic_interp_pkg::Wcoef,
    parameter int    Wout      = 18,
    parameter int    Num_coef  = 17,
    parameter string COEF_FILE = "comp_cic_interp_coef.hex",
    // Elaborated ROM image; COEF_FILE names the hex image this table mirrors.
    parameter logic [Wcoef-1:0] COEF [2**comp_cic_interp_pkg::c_ROM_AW] =
        comp_cic_interp_pkg::c_COEF_DEFAULT
) (
    input  logic            clk,
    input  logic            ic_rst_n,
    input  logic [Win-1:0]  id_data_filter,
    input  logic            ic_val_data,
    output logic            oc_ready,
    output logic [Wout-1:0] od_data_filter,
    output logic            oc_val_data,
    output logic            oc_drop
);
    import comp_cic_interp_pkg::*;

    localparam int         c_WPROD = Win + Wcoef;
    localparam int         c_WT    = Wacc - c_TRUNC;
    localparam logic [3:0] c_T0    = 4'(NTAP0 - 1);
    localparam logic [3:0] c_T1    = 4'(NTAP1 - 1);
    localparam logic [3:0] c_TF0   = 4'(c_PIPE_DEPTH - 1);
    localparam logic [3:0] c_TF1   = 4'(c_PIPE_DEPTH);

    state_t                    r_state_q, w_state_d;
    logic [3:0]                r_cnt_q, w_cnt_d;
    logic                      w_ready, w_accept, w_issue, w_first, w_last;
    logic [c_ROM_AW-1:0]       w_rom_addr;
    logic [Wcoef-1:0]          w_coef;
    logic signed [Wcoef-1:0]   w_coef_s;
    logic signed [Win-1:0]     r_dline_q [NTAP0];
    logic signed [Win-1:0]     w_dline_d [NTAP0];
    logic signed [Win-1:0]     r_x1_q, w_x1_d;
    logic                      r_v1_q, w_v1_d, r_f1_q, w_f1_d, r_l1_q, w_l1_d;
    logic signed [c_WPROD-1:0] r_prod_q, w_prod_d;
    logic                      r_v2_q, w_v2_d, r_f2_q, w_f2_d, r_l2_q, w_l2_d;
    logic signed [Wacc-1:0]    r_acc_q, w_acc_d, w_prod_ext;
    logic [c_WT-1:0]           w_trunc;
    logic [c_WT-Wout:0]        w_hi;
    logic [Wout-1:0]           w_sat;
    logic [Wout-1:0]           r_out_q, w_out_d;
    logic                      r_val_q, w_val_d, r_drop_q, w_drop_d;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!ic_rst_n) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // FLUSH1 holds one cycle past the pipeline drain so the y1 pulse
    // precedes ready, giving a 23-cycle accept-to-accept period.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q + 4'd1;
        case (r_state_q)
            S_IDLE: begin
                w_cnt_d = '0;
                if (w_accept) w_state_d = S_MAC0;
            end
            S_MAC0: if (r_cnt_q == c_T0) begin
                w_state_d = S_FLUSH0;
                w_cnt_d   = '0;
            end
            S_FLUSH0: if (r_cnt_q == c_TF0) begin
                w_state_d = S_MAC1;
                w_cnt_d   = '0;
            end
            S_MAC1: if (r_cnt_q == c_T1) begin
                w_state_d = S_FLUSH1;
                w_cnt_d   = '0;
            end
            S_FLUSH1: if (r_cnt_q == c_TF1) begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_ready    = (r_state_q == S_IDLE);
        w_issue    = (r_state_q == S_MAC0) || (r_state_q == S_MAC1);
        w_first    = (r_cnt_q == 4'd0);
        w_last     = ((r_state_q == S_MAC0) && (r_cnt_q == c_T0)) ||
                     ((r_state_q == S_MAC1) && (r_cnt_q == c_T1));
        w_rom_addr = '0;
        if (r_state_q == S_MAC0) w_rom_addr = {r_cnt_q, 1'b0};
        if (r_state_q == S_MAC1) w_rom_addr = {r_cnt_q, 1'b1};
    end

    assign w_accept = ic_val_data & w_ready;

    comp_cic_interp_rom #(
        .W     (Wcoef),
        .DEPTH (Num_coef),
        .COEF  (COEF)
    ) u_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_coef)
    );

    // ---------------- datapath ----------------
    always_comb begin
        for (int k = 0; k < NTAP0; k++) w_dline_d[k] = r_dline_q[k];
        if (w_accept) begin
            w_dline_d[0] = id_data_filter;
            for (int k = 1; k < NTAP0; k++) w_dline_d[k] = r_dline_q[k-1];
        end

        // Stage 1 lines the tap sample up with the registered ROM word.
        w_x1_d = r_dline_q[r_cnt_q];
        w_v1_d = w_issue;
        w_f1_d = w_first;
        w_l1_d = w_last;

        w_coef_s = w_coef;
        w_prod_d = c_WPROD'(r_x1_q) * c_WPROD'(w_coef_s);
        w_v2_d   = r_v1_q;
        w_f2_d   = r_f1_q;
        w_l2_d   = r_l1_q;

        // The first product of a phase replaces the accumulator (clear).
        w_prod_ext = {{(Wacc-c_WPROD){r_prod_q[c_WPROD-1]}}, r_prod_q};
        w_acc_d    = r_acc_q;
        if (r_v2_q) w_acc_d = r_f2_q ? w_prod_ext : (r_acc_q + w_prod_ext);

        w_trunc = w_acc_d[Wacc-1:c_TRUNC];
        w_hi    = w_trunc[c_WT-1:Wout-1];
        w_sat   = w_trunc[Wout-1:0];
        if ((w_hi != '0) && (w_hi != '1)) begin
            w_sat = w_trunc[c_WT-1] ? {1'b1, {(Wout-1){1'b0}}} : {1'b0, {(Wout-1){1'b1}}};
        end

        w_out_d = r_out_q;
        w_val_d = 1'b0;
        if (r_v2_q && r_l2_q) begin
            w_out_d = w_sat;
            w_val_d = 1'b1;
        end
        w_drop_d = ic_val_data & ~w_ready;
    end

    always_ff @(posedge clk) begin
        if (!ic_rst_n) begin
            for (int k = 0; k < NTAP0; k++) r_dline_q[k] <= '0;
            r_x1_q   <= '0;
            r_v1_q   <= 1'b0;
            r_f1_q   <= 1'b0;
            r_l1_q   <= 1'b0;
            r_prod_q <= '0;
            r_v2_q   <= 1'b0;
            r_f2_q   <= 1'b0;
            r_l2_q   <= 1'b0;
            r_acc_q  <= '0;
            r_out_q  <= '0;
            r_val_q  <= 1'b0;
            r_drop_q <= 1'b0;
        end else begin
            for (int k = 0; k < NTAP0; k++) r_dline_q[k] <= w_dline_d[k];
            r_x1_q   <= w_x1_d;
            r_v1_q   <= w_v1_d;
            r_f1_q   <= w_f1_d;
            r_l1_q   <= w_l1_d;
            r_prod_q <= w_prod_d;
            r_v2_q   <= w_v2_d;
            r_f2_q   <= w_f2_d;
            r_l2_q   <= w_l2_d;
            r_acc_q  <= w_acc_d;
            r_out_q  <= w_out_d;
            r_val_q  <= w_val_d;
            r_drop_q <= w_drop_d;
        end
    end

    assign oc_ready       = w_ready;
    assign od_data_filter = r_out_q;
    assign oc_val_data    = r_val_q;
    assign oc_drop        = r_drop_q;

endmodule
`default_nettype wire
